connection_table_scanner: RTL and testbench
===========================================

Name: connection_table_scanner

Overview:
- Consumer/driver stage directly downstream of the connection table memory.
- On a start request, sweeps every (src_node, node_B) entry of the table, one read per cycle.
- Returns the lowest-weight edge from src_node to an unvisited neighbour over a valid/ready result handshake.
- Serves as the neighbour-selection step of the graph algorithm.

Parameters:
- DATA_WIDTH, 6, edge weight width; must match the table's data width.
- NODE_ADDRESS_SIZE, 4, node index width; NUM_NODES = 1 << NODE_ADDRESS_SIZE (localparam, 16 at default).

Ports:
- CLK  input  1  single clock, all logic on its rising edge.
- RST  input  1  synchronous active-high reset.
- start  input  1  request a scan; sampled only in IDLE.
- src_node  input  NODE_ADDRESS_SIZE  source node; latched on start accept.
- visited_mask  input  NUM_NODES  bit i = 1 excludes node i; latched on start accept.
- busy  output  1  high in every state except IDLE.
- tbl_node_A  output  NODE_ADDRESS_SIZE  table row address; equals latched src.
- tbl_node_B  output  NODE_ADDRESS_SIZE  table column address.
- tbl_chip_select  output  1  table enable; high only while issuing reads.
- tbl_write_enable  output  1  constant 0.
- tbl_data  input  DATA_WIDTH  table OUT; valid one cycle after the address is issued.
- res_valid  output  1  result available.
- res_ready  input  1  result consumed when high together with res_valid.
- res_found  output  1  1 = a qualifying edge exists.
- res_node  output  NODE_ADDRESS_SIZE  winning neighbour index.
- res_weight  output  DATA_WIDTH  winning edge weight.

Behaviour:
- Reset: RST has priority in any state, including mid-scan or mid-result. Next state is IDLE. All outputs are 0: busy, tbl_*, res_*. Best-candidate registers are cleared.
- Weight encoding: 0 = no connection. Weights 1..2^DATA_WIDTH-1 are valid.
- States:
  - IDLE: start=1 latches src_node and visited_mask, then goes to SCAN.
  - SCAN: issues addresses; after the last one goes to DRAIN.
  - DRAIN: evaluates the final data word; goes to RESULT on the next edge.
  - RESULT: holds res_valid=1 and all res_* stable until res_valid&&res_ready; then goes to IDLE.
- Timing, with start sampled in cycle T:
  - Cycles T+1..T+NUM_NODES: tbl_chip_select=1, tbl_node_B = 0,1,..,NUM_NODES-1.
  - Data for column b arrives in cycle T+2+b and is evaluated at the end of that cycle.
  - The last word arrives at T+NUM_NODES+1, in the DRAIN state.
  - res_valid first high in cycle T+NUM_NODES+2 (T+18 at defaults).
- Candidate rule: column b qualifies iff tbl_data != 0, b != src, and visited_mask[b] == 0.
- Winner: qualifying b with strictly smaller weight than the current best. Ties keep the lower index.
- No candidate: res_found=0, res_node=0, res_weight=0.
- start while busy (SCAN, DRAIN or RESULT): ignored, no queuing.
- start and res_ready in the same RESULT cycle: result is consumed, start is ignored, FSM goes to IDLE. A new start is accepted in the following cycle.
- Back-to-back scans: minimum spacing between two start accepts is NUM_NODES+3 cycles, with res_ready held high.
- visited_mask and src_node changes after accept: no effect on the running scan.
- tbl_node_A is held at the latched src through SCAN and DRAIN.

Optional Feature:
- Macro: SCANNER_EDGE_COUNT_EN.
- Defined:
  - Adds output res_count, NODE_ADDRESS_SIZE+1 bits wide: the number of qualifying columns in the scan.
  - Cleared on start accept and on RST.
  - Valid and stable while res_valid is high.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-scan: assert RST at T+5 -> next cycle busy=0, tbl_chip_select=0, res_valid=0; a start after release is accepted normally.
- Basic: table row 3 holds {5:20, 9:7, 12:7}, all others 0, mask 0, src 3 -> tbl_node_B sweeps 0..15 in T+1..T+16; res_valid at T+18; res_found=1, res_node=9, res_weight=7 (tie resolved to 9, the lower index). With SCANNER_EDGE_COUNT_EN: res_count=3.
- Exclusion: same table, visited_mask bit 9 set, entry (3,3)=1 -> res_node=12, res_weight=7; the self entry is ignored.
- Empty row: row 0 all zero, src 0 -> res_found=0, res_node=0, res_weight=0.
- Backpressure: res_ready held 0 for 10 cycles with start pulsed during RESULT -> res_* stable, start ignored; the res_ready=1 cycle completes the handshake; the next start is accepted one cycle later.
- Boundary weights: entry (7,15)=63 is the only edge -> res_node=15, res_weight=63, proving the last column is evaluated in DRAIN.

Source files
------------

// File: rtl/connection_table_scanner.sv
// connection_table_scanner
//
// Neighbour-selection stage that sits directly downstream of the connection
// table memory. On an accepted start it sweeps every column of row src_node,
// one read per cycle. It then returns the lowest-weight edge to an unvisited
// neighbour over a valid/ready handshake.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   start             scan request, sampled only in IDLE
//   src_node          source row, latched on start accept
//   visited_mask      bit i set excludes node i, latched on start accept
//   busy              high in every state except IDLE
//   tbl_node_A/B      table row/column address
//   tbl_chip_select   table enable, high only while issuing reads
//   tbl_write_enable  tied low
//   tbl_data          table read data, one cycle after the address
//   res_valid/ready   result handshake
//   res_found         a qualifying edge exists
//   res_node          winning neighbour index
//   res_weight        winning edge weight
//   res_count         number of qualifying columns (SCANNER_EDGE_COUNT_EN only)
//
// Build option: define SCANNER_EDGE_COUNT_EN to add the res_count port and its counter.

module connection_table_scanner #(
  parameter int unsigned DATA_WIDTH        = 6,
  parameter int unsigned NODE_ADDRESS_SIZE = 4
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               start,
  input  logic [NODE_ADDRESS_SIZE-1:0]       src_node,
  input  logic [(1 << NODE_ADDRESS_SIZE)-1:0] visited_mask,
  output logic                               busy,
  output logic [NODE_ADDRESS_SIZE-1:0]       tbl_node_A,
  output logic [NODE_ADDRESS_SIZE-1:0]       tbl_node_B,
  output logic                               tbl_chip_select,
  output logic                               tbl_write_enable,
  input  logic [DATA_WIDTH-1:0]              tbl_data,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic                               res_found,
  output logic [NODE_ADDRESS_SIZE-1:0]       res_node,
  output logic [DATA_WIDTH-1:0]              res_weight
`ifdef SCANNER_EDGE_COUNT_EN
  ,
  output logic [NODE_ADDRESS_SIZE:0]         res_count
`endif
);

  localparam int unsigned NUM_NODES = 1 << NODE_ADDRESS_SIZE;
  localparam logic [NODE_ADDRESS_SIZE-1:0] LastCol = {NODE_ADDRESS_SIZE{1'b1}};

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StResult} state_e;

  state_e                         state_q, state_d;
  logic [NODE_ADDRESS_SIZE-1:0]   src_q;
  logic [NUM_NODES-1:0]           mask_q;
  logic [NODE_ADDRESS_SIZE-1:0]   col_q;
  // Column whose data is on tbl_data this cycle (read latency is one cycle).
  logic                           eval_vld_q;
  logic [NODE_ADDRESS_SIZE-1:0]   eval_col_q;
  logic                           best_found_q;
  logic [NODE_ADDRESS_SIZE-1:0]   best_node_q;
  logic [DATA_WIDTH-1:0]          best_weight_q;
  logic                           accept;
  logic                           qualify;
  logic                           better;
`ifdef SCANNER_EDGE_COUNT_EN
  logic [NODE_ADDRESS_SIZE:0]     count_q;
`endif

  assign accept  = (state_q == StIdle) && start;
  assign qualify = eval_vld_q && (tbl_data != '0) && (eval_col_q != src_q) &&
                   !mask_q[eval_col_q];
  // Columns arrive in ascending order, so strict less-than keeps the lower index on ties.
  assign better  = !best_found_q || (tbl_data < best_weight_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StScan;
      StScan:   if (col_q == LastCol) state_d = StDrain;
      StDrain:  state_d = StResult;
      StResult: if (res_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StIdle;
      src_q         <= '0;
      mask_q        <= '0;
      col_q         <= '0;
      eval_vld_q    <= 1'b0;
      eval_col_q    <= '0;
      best_found_q  <= 1'b0;
      best_node_q   <= '0;
      best_weight_q <= '0;
`ifdef SCANNER_EDGE_COUNT_EN
      count_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      eval_vld_q <= (state_q == StScan);
      eval_col_q <= col_q;
      if (accept) begin
        src_q         <= src_node;
        mask_q        <= visited_mask;
        col_q         <= '0;
        best_found_q  <= 1'b0;
        best_node_q   <= '0;
        best_weight_q <= '0;
`ifdef SCANNER_EDGE_COUNT_EN
        count_q       <= '0;
`endif
      end else begin
        // Wraps back to zero after the last column.
        if (state_q == StScan) col_q <= col_q + 1'b1;
        if (qualify && better) begin
          best_found_q  <= 1'b1;
          best_node_q   <= eval_col_q;
          best_weight_q <= tbl_data;
        end
`ifdef SCANNER_EDGE_COUNT_EN
        if (qualify) count_q <= count_q + 1'b1;
`endif
      end
    end
  end

  assign busy             = (state_q != StIdle);
  assign tbl_node_A       = src_q;
  assign tbl_node_B       = col_q;
  assign tbl_chip_select  = (state_q == StScan);
  assign tbl_write_enable = 1'b0;
  assign res_valid        = (state_q == StResult);
  // Result fields read as zero outside RESULT so reset and idle look clean.
  assign res_found        = res_valid & best_found_q;
  assign res_node         = res_valid ? best_node_q : '0;
  assign res_weight       = res_valid ? best_weight_q : '0;
`ifdef SCANNER_EDGE_COUNT_EN
  assign res_count        = res_valid ? count_q : '0;
`endif

endmodule

// File: tb/tb_connection_table_scanner.sv
module tb_connection_table_scanner;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  src_node = '0;
  logic [15:0] visited_mask = '0;
  logic        busy;
  logic [3:0]  tbl_node_A, tbl_node_B;
  logic        tbl_chip_select, tbl_write_enable;
  logic [5:0]  tbl_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        res_found;
  logic [3:0]  res_node;
  logic [5:0]  res_weight;
`ifdef SCANNER_EDGE_COUNT_EN
  logic [4:0]  res_count;
`endif

  connection_table_scanner #(.DATA_WIDTH(6), .NODE_ADDRESS_SIZE(4)) dut (
    .CLK(CLK), .RST(RST), .start(start), .src_node(src_node), .visited_mask(visited_mask),
    .busy(busy), .tbl_node_A(tbl_node_A), .tbl_node_B(tbl_node_B),
    .tbl_chip_select(tbl_chip_select), .tbl_write_enable(tbl_write_enable),
    .tbl_data(tbl_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_found(res_found), .res_node(res_node), .res_weight(res_weight)
`ifdef SCANNER_EDGE_COUNT_EN
    , .res_count(res_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Connection table model: registered read, one cycle latency.
  logic [5:0] mem [16][16];
  always @(posedge CLK) if (tbl_chip_select) tbl_data <= mem[tbl_node_A][tbl_node_B];

  typedef struct {
    logic       found;
    logic [3:0] node;
    logic [5:0] weight;
    logic [4:0] count;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every completed handshake.
  always @(negedge CLK) begin
    if (res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        check("result with empty scoreboard", 64'(sb_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res_found", 64'(res_found), 64'(e.found));
        check("res_node", 64'(res_node), 64'(e.node));
        check("res_weight", 64'(res_weight), 64'(e.weight));
`ifdef SCANNER_EDGE_COUNT_EN
        check("res_count", 64'(res_count), 64'(e.count));
`endif
      end
    end
  end

  // Entered just after a rising edge; start is sampled on the next edge (cycle T).
  // Returns just after the edge ending cycle T+18.
  task automatic run_scan(input logic [3:0] src, input logic [15:0] mask, input logic f,
                          input logic [3:0] n, input logic [5:0] w, input logic [4:0] c);
    exp_t e;
    int   bad;
    e.found = f; e.node = n; e.weight = w; e.count = c;
    sb_q.push_back(e);
    src_node = src; visited_mask = mask; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    // Scrambled after accept; must not affect the running scan.
    src_node = ~src; visited_mask = ~mask;
    bad = 0;
    for (int b = 0; b < 16; b++) begin
      @(negedge CLK);
      if (!(tbl_chip_select && busy && tbl_node_B == 4'(b) && tbl_node_A == src &&
            !tbl_write_enable && !res_valid)) bad++;
    end
    check("sweep cycles wrong", 64'(bad), 64'd0);
    @(negedge CLK);
    check("drain {cs,valid,busy}", 64'({tbl_chip_select, res_valid, busy}), 64'b001);
    @(negedge CLK);
    check("res_valid at T+18", 64'({res_valid, busy}), 64'b11);
    @(posedge CLK); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [10:0] snap;
    int          bad;
    for (int a = 0; a < 16; a++) for (int b = 0; b < 16; b++) mem[a][b] = '0;
    mem[3][5] = 6'd20; mem[3][9] = 6'd7; mem[3][12] = 6'd7; mem[3][3] = 6'd1;
    mem[7][15] = 6'd63;
    mem[5][0] = 6'd1; mem[5][1] = 6'd1; mem[5][15] = 6'd1; mem[5][5] = 6'd2;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset outputs", 64'({busy, tbl_chip_select, tbl_write_enable, res_valid, res_found,
                                res_node, res_weight, tbl_node_A, tbl_node_B}), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // Reset mid-scan: RST held during cycle T+5
    src_node = 4'd3; visited_mask = '0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("after mid-scan reset {busy,cs,valid}",
          64'({busy, tbl_chip_select, res_valid}), 64'd0);
    @(posedge CLK); #1;

    // Basic: tie at weight 7 resolves to node 9
    run_scan(4'd3, 16'h0000, 1'b1, 4'd9, 6'd7, 5'd3);
    // Exclusion: node 9 visited, self entry ignored
    run_scan(4'd3, 16'h0200, 1'b1, 4'd12, 6'd7, 5'd2);
    // Empty row
    run_scan(4'd0, 16'h0000, 1'b0, 4'd0, 6'd0, 5'd0);
    // Last column, max weight, evaluated in DRAIN
    run_scan(4'd7, 16'h0000, 1'b1, 4'd15, 6'd63, 5'd1);
    // Masked lowest index, tie among remaining resolves low, self ignored
    run_scan(4'd5, 16'h0001, 1'b1, 4'd1, 6'd1, 5'd2);

    // Backpressure with start pulsed during RESULT
    res_ready = 1'b0;
    run_scan(4'd3, 16'h0000, 1'b1, 4'd9, 6'd7, 5'd3);
    bad = 0;
    snap = '0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      @(negedge CLK);
      if (i == 0) snap = {res_found, res_node, res_weight};
      if (!(res_valid && busy && {res_found, res_node, res_weight} == snap)) bad++;
      @(posedge CLK); #1;
    end
    check("result unstable under backpressure", 64'(bad), 64'd0);
    check("held result value", 64'(snap), 64'({1'b1, 4'd9, 6'd7}));
    // Handshake cycle with simultaneous start: start must be ignored
    res_ready = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check("idle after handshake", 64'({busy, res_valid}), 64'd0);
    // Accepted in the very next cycle
    run_scan(4'd7, 16'h0000, 1'b1, 4'd15, 6'd63, 5'd1);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge CLK);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
